counter_chain: RTL and testbench
================================

# counter_chain

Parametrised synchronous binary counter built from cascaded 4-bit 74xx161-style slices, with up/down counting, synchronous parallel load and a sticky wrap flag. It replaces hand-chained 4-bit counter instances in the emulator (program counter, address and step counters). It exposes the same CEP/CET/TC enable-and-carry semantics, so instances still cascade with each other and with discrete 4-bit counters.

## Interface

- `NIBBLES`, default 3: number of 4-bit slices; counter width W = 4·NIBBLES, legal range 1..8.
- `clk` input 1: single clock, all state updates on rising edge.
- `mrn` input 1: reset, synchronous, active-low; sampled on rising edge of `clk`.
- `pen` input 1: parallel load enable, active-low.
- `d` input W: parallel load data.
- `cep` input 1: count enable, parallel.
- `cet` input 1: count enable, trickle (carry in); also gates `tc`.
- `up` input 1: direction, 1 = increment, 0 = decrement.
- `q` output W: counter value, registered.
- `tc` output 1: terminal count, combinational.
- `wrap` output 1: sticky wrap-around flag, registered.

## Operation

- Priority per rising edge: `mrn`=0 → `q`=0, `wrap`=0; else `pen`=0 → `q`=`d`, `wrap`=0 (load ignores `cep`/`cet`/`up`); else `cep`&`cet` → count; else hold.
- Count: `q` ← `q`+1 (up) or `q`−1 (down), modulo 2^W; all slices advance on the same edge (no ripple clocking).
- Slice k counts iff `cep` & `cet` & all lower slices at their terminal value for the current direction. Terminal value is F when up, 0 when down.
- `tc` = `cet` & (`q` == 2^W−1 when `up`=1, `q` == 0 when `up`=0). It is purely combinational and does not depend on `cep`, so the next instance's `cet` can be driven directly from it.
- `wrap` is set on any count edge where `tc`=1, i.e. up FFF→000 or down 000→FFF for NIBBLES=3. It stays set until reset or load. Hold cycles do not clear it.
- Changing `up` takes effect on the next counting edge. `tc` re-evaluates immediately.
- Reset mid-count overrides load and count on the same edge. There is no asynchronous path: `q` keeps its value until the edge that samples `mrn`=0.

## Timing

- Reset values: `q`=0, `wrap`=0; `tc` = `cet` & `up`=0 (zero is terminal in down mode).
- Load latency: 1 cycle. `d` appears on `q` after the edge that samples `pen`=0.
- Count latency: 1 cycle per step. `tc` is valid in the same cycle as `q` (combinational settle).
- `wrap` rises on the same edge that `q` wraps.
- Combinational path `cet`→`tc` is one AND level per instance. A chain of M instances has M AND levels; no registered carry.
- Simultaneous `pen`=0 with `cep`=`cet`=1: load wins, `wrap` cleared even if `tc`=1.

## Structure

- Shared package `counter_pkg`: slice width constant `SLICE_W = 4`, terminal constants `SLICE_MAX = 4'hF`, `SLICE_MIN = 4'h0`.
- One sub-module `counter_slice`: 4-bit register with load, up/down, local `tc` (`cet` & terminal). It is instantiated NIBBLES times via generate, with each slice's `tc` feeding the next slice's `cet`.
- Top level adds only the `wrap` register and concatenation of slice outputs. `tc` equals the top slice's `tc`.

## Test plan

- Reset then free-run up, NIBBLES=3, `cep`=`cet`=1: `q` steps 000…FFF over 4096 edges. `tc`=1 only at FFF. The next edge gives `q`=000 and `wrap`=1.
- Down count from reset: first edge gives `q`=FFF, `wrap`=1. `tc` is 1 at `q`=000 with `up`=0. Slice boundary 100→0FF is correct.
- Load: `pen`=0, `d`=0x7FE, `cep`=0 → `q`=7FE next edge, `wrap` cleared. Count up twice → 7FF then 800, with carry across two slices on one edge.
- Enable gating: `cet`=0 holds `q` and forces `tc`=0 with `q`=FFF. `cep`=0, `cet`=1 holds `q` but `tc`=1 at FFF.
- Cascade: two NIBBLES=2 instances, upper `cet` = lower `tc`, shared `cep`. Combined 16-bit value matches a 0..65535 reference counter, and the upper instance's `wrap` sets only at FFFF→0000.
- Priority: assert `mrn`=0, `pen`=0, `cep`=`cet`=1 together at `q`=FFF → `q`=000, `wrap`=0. `q` is unchanged before that edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the cascaded 74xx161-style counter slices.
package counter_pkg;
  localparam int SLICE_W = 4;
  localparam logic [SLICE_W-1:0] SLICE_MAX = 4'hF;
  localparam logic [SLICE_W-1:0] SLICE_MIN = 4'h0;
endpackage

// File: rtl/counter_slice.sv
// One 4-bit up/down counter slice with synchronous reset/load and a local
// terminal-count output gated by the trickle enable.
module counter_slice
  import counter_pkg::*;
(
  input  logic               clk,
  input  logic               mrn,
  input  logic               pen,
  input  logic [SLICE_W-1:0] d,
  input  logic               cep,
  input  logic               cet,
  input  logic               up,
  output logic [SLICE_W-1:0] q,
  output logic               tc
);

  always_ff @(posedge clk) begin
    if (!mrn) begin
      q <= SLICE_MIN;
    end else if (!pen) begin
      q <= d;
    end else if (cep && cet) begin
      q <= up ? q + 4'd1 : q - 4'd1;
    end
  end

  // Terminal value depends on direction: F when counting up, 0 when down.
  assign tc = cet & (up ? (q == SLICE_MAX) : (q == SLICE_MIN));

endmodule

// File: rtl/counter_chain.sv
// W = 4*NIBBLES bit synchronous counter built from cascaded slices; each
// slice's tc drives the next slice's cet, so all slices advance on one edge.
module counter_chain
  import counter_pkg::*;
#(
  parameter int NIBBLES = 3  // legal range 1..8
) (
  input  logic                   clk,
  input  logic                   mrn,
  input  logic                   pen,
  input  logic [4*NIBBLES-1:0]   d,
  input  logic                   cep,
  input  logic                   cet,
  input  logic                   up,
  output logic [4*NIBBLES-1:0]   q,
  output logic                   tc,
  output logic                   wrap
);

  logic [NIBBLES:0] carry;

  assign carry[0] = cet;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_slice
    counter_slice u_slice (
      .clk (clk),
      .mrn (mrn),
      .pen (pen),
      .d   (d[SLICE_W*k +: SLICE_W]),
      .cep (cep),
      .cet (carry[k]),
      .up  (up),
      .q   (q[SLICE_W*k +: SLICE_W]),
      .tc  (carry[k+1])
    );
  end

  assign tc = carry[NIBBLES];

  // Sticky: set whenever a count edge passes through the terminal value.
  always_ff @(posedge clk) begin
    if (!mrn) begin
      wrap <= 1'b0;
    end else if (!pen) begin
      wrap <= 1'b0;
    end else if (cep && tc) begin
      wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_chain.sv
// Directed bench for counter_chain: a 12-bit instance plus a cascade of two
// 8-bit instances checked against a 16-bit reference count.
module tb_counter_chain;

  logic        clk = 1'b0;
  logic        mrn, pen, cep, cet, up;
  logic [11:0] d;
  logic [11:0] q;
  logic        tc, wrap;

  logic        c_mrn, c_pen, c_cep, c_up;
  logic [15:0] c_d;
  logic [7:0]  lo_q, hi_q;
  logic        lo_tc, hi_tc, lo_wrap, hi_wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_chain #(.NIBBLES(3)) dut (
    .clk(clk), .mrn(mrn), .pen(pen), .d(d), .cep(cep), .cet(cet), .up(up),
    .q(q), .tc(tc), .wrap(wrap)
  );

  counter_chain #(.NIBBLES(2)) u_lo (
    .clk(clk), .mrn(c_mrn), .pen(c_pen), .d(c_d[7:0]), .cep(c_cep), .cet(1'b1),
    .up(c_up), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );

  counter_chain #(.NIBBLES(2)) u_hi (
    .clk(clk), .mrn(c_mrn), .pen(c_pen), .d(c_d[15:8]), .cep(c_cep), .cet(lo_tc),
    .up(c_up), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mrn = 1'b0; pen = 1'b1; cep = 1'b0; cet = 1'b1; up = 1'b1; d = '0;
    c_mrn = 1'b0; c_pen = 1'b1; c_cep = 1'b0; c_up = 1'b1; c_d = '0;

    // Reset state
    step();
    chk("reset_q", 32'(q), 0);
    chk("reset_wrap", 32'(wrap), 0);
    chk("reset_tc_up", 32'(tc), 0);
    up = 1'b0; #1;
    chk("reset_tc_down", 32'(tc), 1);
    up = 1'b1; #1;

    // Free-run up over the full range
    mrn = 1'b1; cep = 1'b1;
    for (int i = 1; i < 4096; i++) begin
      step();
      chk("up_q", 32'(q), 32'(i));
      chk("up_tc", 32'(tc), 32'(i == 4095));
    end
    chk("up_wrap_before", 32'(wrap), 0);
    step();
    chk("up_wrap_q", 32'(q), 0);
    chk("up_wrap_flag", 32'(wrap), 1);
    chk("up_wrap_tc", 32'(tc), 0);
    cep = 1'b0;
    step();
    chk("hold_keeps_wrap", 32'(wrap), 1);
    chk("hold_q", 32'(q), 0);

    // Down count from reset
    mrn = 1'b0;
    step();
    chk("rst2_q", 32'(q), 0);
    chk("rst2_wrap", 32'(wrap), 0);
    mrn = 1'b1; up = 1'b0; cep = 1'b1; #1;
    chk("down_tc_zero", 32'(tc), 1);
    step();
    chk("down_q_fff", 32'(q), 32'hFFF);
    chk("down_wrap", 32'(wrap), 1);
    chk("down_tc_fff", 32'(tc), 0);
    pen = 1'b0; d = 12'h100;
    step();
    chk("load_100", 32'(q), 32'h100);
    chk("load_clears_wrap", 32'(wrap), 0);
    pen = 1'b1;
    step();
    chk("down_boundary", 32'(q), 32'h0FF);
    chk("down_boundary_wrap", 32'(wrap), 0);

    // Load and carry across two slices
    pen = 1'b0; d = 12'hFFF; up = 1'b1;
    step();
    pen = 1'b1;
    step();
    chk("wrap_set_again", 32'(wrap), 1);
    pen = 1'b0; d = 12'h7FE; cep = 1'b0;
    step();
    chk("load_7fe", 32'(q), 32'h7FE);
    chk("load_7fe_wrap", 32'(wrap), 0);
    pen = 1'b1; cep = 1'b1;
    step();
    chk("count_7ff", 32'(q), 32'h7FF);
    step();
    chk("count_800", 32'(q), 32'h800);

    // Direction change: tc re-evaluates immediately
    up = 1'b0; #1;
    chk("dir_tc_800", 32'(tc), 0);
    step();
    chk("dir_down_7ff", 32'(q), 32'h7FF);
    up = 1'b1;

    // Enable gating at FFF
    pen = 1'b0; d = 12'hFFF;
    step();
    pen = 1'b1; cet = 1'b0; cep = 1'b1; #1;
    chk("cet0_tc", 32'(tc), 0);
    step();
    chk("cet0_hold", 32'(q), 32'hFFF);
    cet = 1'b1; cep = 1'b0; #1;
    chk("cep0_tc", 32'(tc), 1);
    step();
    chk("cep0_hold", 32'(q), 32'hFFF);
    chk("cep0_wrap", 32'(wrap), 0);

    // Load wins over count at terminal count
    cep = 1'b1;
    step();
    chk("wrap_pre_load", 32'(wrap), 1);
    pen = 1'b0; d = 12'hFFF;
    step();
    pen = 1'b1; up = 1'b0;
    step();
    chk("dn_from_fff", 32'(q), 32'hFFE);
    up = 1'b1;
    step();
    chk("back_to_fff", 32'(q), 32'hFFF);
    pen = 1'b0; d = 12'h123; #1;
    chk("load_vs_count_tc", 32'(tc), 1);
    step();
    chk("load_vs_count_q", 32'(q), 32'h123);
    chk("load_vs_count_wrap", 32'(wrap), 0);

    // Priority: reset beats load and count, no asynchronous effect
    d = 12'hFFF;
    step();
    pen = 1'b1; up = 1'b1;
    step();
    up = 1'b0;
    step();
    chk("prio_pre_q", 32'(q), 32'hFFF);
    chk("prio_pre_wrap", 32'(wrap), 1);
    mrn = 1'b0; pen = 1'b0; d = 12'h555; cep = 1'b1; cet = 1'b1; #2;
    chk("prio_no_async", 32'(q), 32'hFFF);
    step();
    chk("prio_q", 32'(q), 0);
    chk("prio_wrap", 32'(wrap), 0);
    mrn = 1'b1; pen = 1'b1; cep = 1'b0;

    // Cascade of two 8-bit instances against a 16-bit reference
    step();
    chk("casc_reset", 32'({hi_q, lo_q}), 0);
    c_mrn = 1'b1; c_cep = 1'b1;
    for (int i = 1; i <= 65536; i++) begin
      step();
      chk("casc_q", 32'({hi_q, lo_q}), 32'(i % 65536));
      chk("casc_hi_wrap", 32'(hi_wrap), 32'(i >= 65536));
    end
    chk("casc_lo_wrap", 32'(lo_wrap), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
